async_fifo_write_controller: RTL and testbench
==============================================

ASYNC_FIFO_WRITE_CONTROLLER -- requirements
Module: async_fifo_write_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default CLOG2(DEPTH), RAM address width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, read-pointer synchronizer depth, >= 2.
REQ-005 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-1, level at which almost_full asserts.
REQ-006 SHALL have ports: write_clock  input  1  write-domain clock; reset write_resetn, asynchronous, active-low; clock write_clock.
REQ-007 write_resetn  input  1  asynchronous active-low reset.
REQ-008 write_enable  input  1  push request.
REQ-009 write_data  input  WIDTH  push data.
REQ-010 overflow_clear  input  1  clears sticky overflow.
REQ-011 read_pointer_gray  input  ADDRESS_WIDTH+1  read-domain Gray pointer, asynchronous to write_clock.
REQ-012 full  output  1  no push accepted.
REQ-013 almost_full  output  1  level >= ALMOST_FULL_LEVEL.
REQ-014 level  output  ADDRESS_WIDTH+1  pessimistic occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky: push attempted while full.
REQ-016 ram_write_enable / ram_write_address / ram_write_data  output  1 / ADDRESS_WIDTH / WIDTH  drive dual-port RAM write port.
REQ-017 write_pointer_gray  output  ADDRESS_WIDTH+1  registered Gray write pointer to read domain.

Function
REQ-018 Write pointer SHALL be an ADDRESS_WIDTH+1-bit binary counter, wrapping modulo 2*DEPTH.
REQ-019 A push SHALL be accepted in a cycle iff write_enable=1 and full=0.
REQ-020 ram_write_enable SHALL equal write_enable AND NOT full, combinationally, same cycle.
REQ-021 ram_write_address SHALL equal the low ADDRESS_WIDTH bits of the binary write pointer; ram_write_data SHALL equal write_data.
REQ-022 On an accepted push the binary pointer SHALL increment by 1 at the next write_clock edge.
REQ-023 write_pointer_gray SHALL be a register equal to bin XOR (bin >> 1) of the updated pointer, changing by exactly one bit per push.
REQ-024 read_pointer_gray SHALL pass through SYNC_STAGES flops before any use; synchronized value converted Gray-to-binary.
REQ-025 level SHALL equal (write pointer - synchronized read pointer) modulo 2*DEPTH, from registered values only.
REQ-026 full SHALL assert iff level = DEPTH (pointers differ only in MSB); no combinational path from write_enable to full.
REQ-027 almost_full SHALL assert iff level >= ALMOST_FULL_LEVEL.
REQ-028 Read-side pops SHALL lower level/full no earlier than SYNC_STAGES+1 write_clock cycles after read_pointer_gray changes (pessimistic).
REQ-029 Push while full SHALL be dropped, pointer unchanged, overflow set next cycle.
REQ-030 overflow_clear SHALL clear overflow; a simultaneous new overflow event SHALL win (overflow stays 1).
REQ-031 Wrap-around at 2*DEPTH-1 -> 0 SHALL keep full/level correct.

Reset
REQ-032 write_resetn low SHALL asynchronously clear pointer, write_pointer_gray, all synchronizer flops and overflow to 0.
REQ-033 During and after reset: full=0, almost_full=0 (unless ALMOST_FULL_LEVEL=0), level=0, ram_write_enable=write_enable.
REQ-034 Reset mid-operation SHALL discard FIFO state; read domain SHALL be reset concurrently by system convention.

Structure
REQ-035 Gray/binary conversion functions SHALL live in the shared common package, reusable by the read-side controller.
REQ-036 Synchronizer SHALL be a sub-module gray_pointer_synchronizer (SYNC_STAGES flops, parameterized width).
REQ-037 Block SHALL pair with ram_dual_port_async write port and a matching read controller.

Verification (DEPTH=4, SYNC_STAGES=2)
REQ-038 Reset, then 4 pushes with read_pointer_gray=0 -> addresses 0,1,2,3; level 1..4; full=1 after 4th; write_pointer_gray=3'b110.
REQ-039 5th push while full -> ram_write_enable=0, pointer unchanged, overflow=1; overflow_clear -> overflow=0.
REQ-040 Full, read_pointer_gray 0->1 -> full deasserts exactly 3 cycles later, level=3.
REQ-041 Push/pop 10 entries continuously -> pointer wraps 7->0, full never falsely asserts, level correct.
REQ-042 Assert write_resetn low mid-burst -> all outputs reset immediately, next push targets address 0.

Source files
------------

// File: rtl/async_fifo_write_controller_pkg.sv
// Shared pointer helpers for the async FIFO controllers. Both the write and the read side
// use these helpers so the two domains agree on the Gray encoding.
package async_fifo_write_controller_pkg;

    localparam int POINTER_FUNCTION_WIDTH = 32;

    typedef logic [POINTER_FUNCTION_WIDTH-1:0] pointer_word_t;

    function automatic pointer_word_t binary_to_gray(input pointer_word_t binary);
        return binary ^ (binary >> 1);
    endfunction

    // Callers zero-extend narrower pointers, so the leading zeros decode to zero.
    function automatic pointer_word_t gray_to_binary(input pointer_word_t gray);
        pointer_word_t binary;
        binary[POINTER_FUNCTION_WIDTH-1] = gray[POINTER_FUNCTION_WIDTH-1];
        for (int i = POINTER_FUNCTION_WIDTH - 2; i >= 0; i--) begin
            binary[i] = binary[i+1] ^ gray[i];
        end
        return binary;
    endfunction

endpackage

// File: rtl/async_fifo_write_controller_synchronizer.sv
// Multi-flop synchronizer that brings a Gray-coded pointer into the local clock domain.
module gray_pointer_synchronizer #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] async_pointer,
    output logic [WIDTH-1:0] sync_pointer
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= async_pointer;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign sync_pointer = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_write_controller.sv
// Write-side controller of an asynchronous FIFO: owns the write pointer, the RAM write port
// and a pessimistic full/level view built from the synchronized read pointer.
module async_fifo_write_controller
    import async_fifo_write_controller_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int DEPTH             = 16,
    parameter int ADDRESS_WIDTH     = $clog2(DEPTH),
    parameter int SYNC_STAGES       = 2,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                     write_clock,
    input  logic                     write_resetn,
    input  logic                     write_enable,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     overflow_clear,
    input  logic [ADDRESS_WIDTH:0]   read_pointer_gray,
    output logic                     full,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     overflow,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic [WIDTH-1:0]         ram_write_data,
    output logic [ADDRESS_WIDTH:0]   write_pointer_gray
);

    localparam int POINTER_WIDTH = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] FULL_LEVEL = POINTER_WIDTH'(DEPTH);

    logic [ADDRESS_WIDTH:0] write_pointer;
    logic [ADDRESS_WIDTH:0] write_pointer_next;
    logic [ADDRESS_WIDTH:0] read_pointer_sync_gray;
    logic [ADDRESS_WIDTH:0] read_pointer_binary;
    logic                   push;

    gray_pointer_synchronizer #(
        .WIDTH (POINTER_WIDTH),
        .STAGES(SYNC_STAGES)
    ) read_pointer_synchronizer (
        .clock        (write_clock),
        .resetn       (write_resetn),
        .async_pointer(read_pointer_gray),
        .sync_pointer (read_pointer_sync_gray)
    );

    assign push               = write_enable && !full;
    assign write_pointer_next = write_pointer + POINTER_WIDTH'(1);

    // The decoded read pointer is registered once more, so pops reach level one cycle after sync.
    always_ff @(posedge write_clock or negedge write_resetn) begin
        if (!write_resetn) begin
            write_pointer       <= '0;
            write_pointer_gray  <= '0;
            read_pointer_binary <= '0;
            overflow            <= 1'b0;
        end else begin
            read_pointer_binary <= POINTER_WIDTH'(gray_to_binary(
                                       POINTER_FUNCTION_WIDTH'(read_pointer_sync_gray)));
            if (push) begin
                write_pointer      <= write_pointer_next;
                write_pointer_gray <= POINTER_WIDTH'(binary_to_gray(
                                          POINTER_FUNCTION_WIDTH'(write_pointer_next)));
            end
            if (write_enable && full) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    assign level       = write_pointer - read_pointer_binary;
    assign full        = (level == FULL_LEVEL);
    assign almost_full = (32'(level) >= 32'(ALMOST_FULL_LEVEL));

    assign ram_write_enable  = push;
    assign ram_write_address = write_pointer[ADDRESS_WIDTH-1:0];
    assign ram_write_data    = write_data;

endmodule

// File: tb/tb_async_fifo_write_controller.sv
// Self-checking bench for async_fifo_write_controller with DEPTH=4, SYNC_STAGES=2; RAM writes
// are checked against a scoreboard queue filled as pushes are driven.
module tb_async_fifo_write_controller;

    typedef struct packed {
        logic [1:0] address;
        logic [7:0] data;
    } write_t;

    logic       write_clock;
    logic       write_resetn;
    logic       write_enable;
    logic [7:0] write_data;
    logic       overflow_clear;
    logic [2:0] read_pointer_gray;
    logic       full;
    logic       almost_full;
    logic [2:0] level;
    logic       overflow;
    logic       ram_write_enable;
    logic [1:0] ram_write_address;
    logic [7:0] ram_write_data;
    logic [2:0] write_pointer_gray;

    int     checks = 0;
    int     errors = 0;
    write_t expected_writes[$];
    logic [2:0] model_write_pointer;

    async_fifo_write_controller #(
        .WIDTH      (8),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .write_clock       (write_clock),
        .write_resetn      (write_resetn),
        .write_enable      (write_enable),
        .write_data        (write_data),
        .overflow_clear    (overflow_clear),
        .read_pointer_gray (read_pointer_gray),
        .full              (full),
        .almost_full       (almost_full),
        .level             (level),
        .overflow          (overflow),
        .ram_write_enable  (ram_write_enable),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .write_pointer_gray(write_pointer_gray)
    );

    initial begin
        write_clock = 1'b0;
        forever #5 write_clock = ~write_clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2:0] to_gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge write_clock);
        #1;
    endtask

    // Scoreboard consumer: every RAM write seen mid-cycle must match the oldest expected write.
    always @(negedge write_clock) begin
        if (ram_write_enable === 1'b1) begin
            write_t exp_w;
            checks++;
            if (expected_writes.size() == 0) begin
                errors++;
                $display("[TB] FAIL ram_write unexpected: address %0d data %02h, none expected",
                         ram_write_address, ram_write_data);
            end else begin
                exp_w = expected_writes.pop_front();
                if (ram_write_address !== exp_w.address || ram_write_data !== exp_w.data) begin
                    errors++;
                    $display("[TB] FAIL ram_write: got address %0d data %02h, expected address %0d data %02h",
                             ram_write_address, ram_write_data, exp_w.address, exp_w.data);
                end
            end
        end
    end

    task automatic test_reset();
        write_resetn      = 1'b0;
        write_enable      = 1'b0;
        write_data        = 8'h00;
        overflow_clear    = 1'b0;
        read_pointer_gray = 3'b000;
        tick();
        tick();
        checks++;
        if ({full, almost_full, level, overflow, write_pointer_gray} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got full %b almost_full %b level %0d overflow %b wpg %b, expected all 0",
                     full, almost_full, level, overflow, write_pointer_gray);
        end
        write_enable = 1'b1;
        write_data   = 8'h11;
        expected_writes.push_back('{address: 2'd0, data: 8'h11});
        #1;
        checks++;
        if (ram_write_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ram_enable: got %b expected 1", ram_write_enable);
        end
        tick();
        write_enable = 1'b0;
        tick();
        write_resetn = 1'b1;
        model_write_pointer = 3'd0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            write_enable = 1'b1;
            write_data   = 8'hA0 + 8'(i);
            expected_writes.push_back('{address: 2'(i), data: write_data});
            tick();
            model_write_pointer++;
            checks++;
            if (level !== 3'(i + 1) || full !== (i == 3) || almost_full !== (i + 1 >= 3)) begin
                errors++;
                $display("[TB] FAIL fill_%0d: got level %0d full %b almost_full %b, expected level %0d full %b almost_full %b",
                         i, level, full, almost_full, i + 1, (i == 3), (i + 1 >= 3));
            end
        end
        write_enable = 1'b0;
        checks++;
        if (write_pointer_gray !== 3'b110) begin
            errors++;
            $display("[TB] FAIL fill_gray: got %b expected 110", write_pointer_gray);
        end
    endtask

    task automatic test_overflow();
        write_enable = 1'b1;
        write_data   = 8'h55;
        #1;
        checks++;
        if (ram_write_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_ram_enable: got %b expected 0", ram_write_enable);
        end
        tick();
        checks++;
        if (overflow !== 1'b1 || write_pointer_gray !== 3'b110 || level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL overflow_set: got overflow %b wpg %b level %0d, expected 1 110 4",
                     overflow, write_pointer_gray, level);
        end
        write_enable   = 1'b0;
        overflow_clear = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_clear: got %b expected 0", overflow);
        end
        write_enable = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_priority: got %b expected 1", overflow);
        end
        write_enable = 1'b0;
        tick();
        overflow_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_reclear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_pop_latency();
        logic [2:0] expected_full;
        read_pointer_gray = to_gray(3'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            expected_full = (c < 3) ? 3'd1 : 3'd0;
            checks++;
            if (full !== expected_full[0] || level !== ((c < 3) ? 3'd4 : 3'd3)) begin
                errors++;
                $display("[TB] FAIL pop_latency_cycle_%0d: got full %b level %0d, expected full %b level %0d",
                         c, full, level, expected_full[0], (c < 3) ? 4 : 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] rp_driven;
        logic [2:0] s0, s1, s2;
        logic [2:0] model_level;
        logic       model_full;
        logic       wrapped;
        int         accepted;
        int         cycles;
        rp_driven = 3'd1;
        s0 = 3'd1; s1 = 3'd1; s2 = 3'd1;
        accepted = 0;
        cycles   = 0;
        wrapped  = 1'b0;
        while (accepted < 10 && cycles < 40) begin
            model_level = model_write_pointer - s2;
            model_full  = (model_level == 3'd4);
            checks++;
            if (level !== model_level || full !== model_full ||
                write_pointer_gray !== to_gray(model_write_pointer)) begin
                errors++;
                $display("[TB] FAIL stream_cycle_%0d: got level %0d full %b wpg %b, expected level %0d full %b wpg %b",
                         cycles, level, full, write_pointer_gray, model_level, model_full,
                         to_gray(model_write_pointer));
            end
            write_enable = 1'b1;
            write_data   = 8'hC0 + 8'(cycles);
            if (!model_full) begin
                expected_writes.push_back('{address: model_write_pointer[1:0], data: write_data});
            end
            if (rp_driven != model_write_pointer) begin
                rp_driven = rp_driven + 3'd1;
            end
            read_pointer_gray = to_gray(rp_driven);
            tick();
            if (!model_full) begin
                if (model_write_pointer == 3'd7) wrapped = 1'b1;
                model_write_pointer = model_write_pointer + 3'd1;
                accepted++;
            end
            s2 = s1;
            s1 = s0;
            s0 = rp_driven;
            cycles++;
        end
        write_enable = 1'b0;
        checks++;
        if (accepted != 10 || !wrapped) begin
            errors++;
            $display("[TB] FAIL stream_progress: got %0d accepted wrapped %b, expected 10 accepted wrapped 1",
                     accepted, wrapped);
        end
    endtask

    task automatic test_reset_mid_burst();
        read_pointer_gray = to_gray(model_write_pointer);
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (level !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drained: got level %0d full %b, expected 0 0", level, full);
        end
        for (int i = 0; i < 2; i++) begin
            write_enable = 1'b1;
            write_data   = 8'hE0 + 8'(i);
            expected_writes.push_back('{address: model_write_pointer[1:0], data: write_data});
            tick();
            model_write_pointer = model_write_pointer + 3'd1;
        end
        write_data        = 8'hE2;
        write_resetn      = 1'b0;
        read_pointer_gray = 3'b000;
        expected_writes.push_back('{address: 2'd0, data: 8'hE2});
        #1;
        checks++;
        if (level !== 3'd0 || full !== 1'b0 || overflow !== 1'b0 || write_pointer_gray !== 3'b000 ||
            ram_write_address !== 2'd0 || ram_write_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset: got level %0d full %b overflow %b wpg %b addr %0d we %b, expected 0 0 0 000 0 1",
                     level, full, overflow, write_pointer_gray, ram_write_address, ram_write_enable);
        end
        tick();
        write_enable = 1'b0;
        tick();
        write_resetn = 1'b1;
        model_write_pointer = 3'd0;
        tick();
        write_enable = 1'b1;
        write_data   = 8'h99;
        expected_writes.push_back('{address: 2'd0, data: 8'h99});
        tick();
        write_enable = 1'b0;
        checks++;
        if (write_pointer_gray !== 3'b001 || level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL post_reset_push: got wpg %b level %0d, expected 001 1",
                     write_pointer_gray, level);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_pop_latency();
        test_back_to_back();
        test_reset_mid_burst();
        checks++;
        if (expected_writes.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending writes, expected 0",
                     expected_writes.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
